// File: rtl/psum_pkg.sv
// Shared types, default widths and helpers for the partial-sum accumulator.
package psum_pkg;

    localparam int IN_W_D    = 10;
    localparam int SHIFT_W_D = 4;
    localparam int ACC_W_D   = 32;
    localparam int CNT_W_D   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } psum_state_e;

    // Two's-complement add overflows when both addends share a sign the sum lacks.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/psum_shift_ext.sv
// Sign-extends a PE partial sum to accumulator width and applies its brick shift.
module psum_shift_ext
    import psum_pkg::*;
#(
    parameter int IN_W    = IN_W_D,
    parameter int SHIFT_W = SHIFT_W_D,
    parameter int ACC_W   = ACC_W_D
) (
    input  logic [IN_W-1:0]    i_sum,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic [ACC_W-1:0]   o_operand
);

    logic [ACC_W-1:0] w_ext;

    assign w_ext     = {{(ACC_W-IN_W){i_sum[IN_W-1]}}, i_sum};
    // Bits pushed above ACC_W are dropped; the result wraps by design.
    assign o_operand = w_ext << i_shift;

endmodule

// File: rtl/psum_accumulator.sv
// Shift-add accumulator: folds a programmed number of PE partial sums into one result.
module psum_accumulator
    import psum_pkg::*;
#(
    parameter int IN_W    = IN_W_D,
    parameter int SHIFT_W = SHIFT_W_D,
    parameter int ACC_W   = ACC_W_D,
    parameter int CNT_W   = CNT_W_D
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [CNT_W-1:0]   i_cfg_len,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [IN_W-1:0]    i_in_sum,
    input  logic [SHIFT_W-1:0] i_in_shift,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [ACC_W-1:0]   o_out_data,
    output logic               o_out_ovf,
    output logic               o_busy
);

    psum_state_e      r_state, w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;
    logic             r_ovf;
    logic [ACC_W-1:0] r_out_data;
    logic             r_out_ovf;

    logic [ACC_W-1:0] w_operand;
    logic [ACC_W-1:0] w_sum;
    logic             w_beat_ovf;
    logic             w_accept;
    logic             w_last;
    logic             w_handshake;
    logic             w_load;
    logic [CNT_W-1:0] w_len_cfg;

    psum_shift_ext #(
        .IN_W    (IN_W),
        .SHIFT_W (SHIFT_W),
        .ACC_W   (ACC_W)
    ) u_shift_ext (
        .i_sum     (i_in_sum),
        .i_shift   (i_in_shift),
        .o_operand (w_operand)
    );

    assign w_sum       = r_acc + w_operand;
    assign w_beat_ovf  = add_ovf(r_acc[ACC_W-1], w_operand[ACC_W-1], w_sum[ACC_W-1]);
    assign w_accept    = (r_state == ST_ACCUM) && i_in_valid;
    assign w_last      = w_accept && (r_cnt == r_len - CNT_W'(1));
    assign w_handshake = (r_state == ST_DONE) && i_out_ready;
    assign w_load      = i_start && ((r_state == ST_IDLE) || w_handshake);
    assign w_len_cfg   = (i_cfg_len == '0) ? CNT_W'(1) : i_cfg_len;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_nxt = ST_ACCUM;
            ST_ACCUM: if (w_last)  w_state_nxt = ST_DONE;
            ST_DONE:  if (i_out_ready) w_state_nxt = i_start ? ST_ACCUM : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_len      <= '0;
            r_ovf      <= 1'b0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
        end else if (w_load) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_len <= w_len_cfg;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CNT_W'(1);
            r_ovf <= r_ovf | w_beat_ovf;
            // Result registers only move on the closing beat so DONE presents a stable value.
            if (w_last) begin
                r_out_data <= w_sum;
                r_out_ovf  <= r_ovf | w_beat_ovf;
            end
        end
    end

    assign o_in_ready  = (r_state == ST_ACCUM);
    assign o_out_valid = (r_state == ST_DONE);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_out_data  = r_out_data;
    assign o_out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized and directed bench for psum_accumulator against an arithmetic reference model.
module tb_psum_accumulator;

    localparam int IN_W = 10, SHIFT_W = 4, ACC_W = 32, CNT_W = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_start = 1'b0;
    logic [CNT_W-1:0]   i_cfg_len = '0;
    logic               i_in_valid = 1'b0;
    logic [IN_W-1:0]    i_in_sum = '0;
    logic [SHIFT_W-1:0] i_in_shift = '0;
    logic               i_out_ready = 1'b0;
    logic               o_in_ready, o_out_valid, o_out_ovf, o_busy;
    logic [ACC_W-1:0]   o_out_data;

    logic               t_start = 1'b0;
    logic [CNT_W-1:0]   t_cfg_len = '0;
    logic               t_in_valid = 1'b0;
    logic [IN_W-1:0]    t_in_sum = '0;
    logic [SHIFT_W-1:0] t_in_shift = '0;
    logic               t_out_ready = 1'b0;
    logic               t_in_ready, t_out_valid, t_out_ovf, t_busy;
    logic [19:0]        t_out_data;

    int n_chk = 0;
    int n_fail = 0;
    int bsum[$];
    int bsh[$];

    always #5 clk = ~clk;

    psum_accumulator dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(i_start), .i_cfg_len(i_cfg_len),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_sum(i_in_sum),
        .i_in_shift(i_in_shift), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_data(o_out_data), .o_out_ovf(o_out_ovf), .o_busy(o_busy)
    );

    psum_accumulator #(.ACC_W(20)) dut20 (
        .i_clk(clk), .i_reset(rst_n), .i_start(t_start), .i_cfg_len(t_cfg_len),
        .i_in_valid(t_in_valid), .o_in_ready(t_in_ready), .i_in_sum(t_in_sum),
        .i_in_shift(t_in_shift), .o_out_valid(t_out_valid), .i_out_ready(t_out_ready),
        .o_out_data(t_out_data), .o_out_ovf(t_out_ovf), .o_busy(t_busy)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrap(input longint x, input int w);
        longint m = longint'(1) <<< w;
        longint r = x & (m - 1);
        if (r >= (m >>> 1)) r -= m;
        return r;
    endfunction

    // True-integer sum per beat; overflow means the exact sum left the w-bit signed range.
    function automatic void model(input int w, output longint d, output bit ovf);
        longint acc = 0;
        longint lo = -(longint'(1) <<< (w - 1));
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint op, s;
        ovf = 1'b0;
        foreach (bsum[k]) begin
            op = wrap(longint'(bsum[k]) * (longint'(1) <<< bsh[k]), w);
            s  = acc + op;
            if (s < lo || s > hi) ovf = 1'b1;
            acc = wrap(s, w);
        end
        d = acc;
    endfunction

    task automatic start_job(input int len);
        @(negedge clk);
        i_start = 1'b1;
        i_cfg_len = CNT_W'(len);
        @(negedge clk);
        i_start = 1'b0;
        chk("start_in_ready", o_in_ready, 1);
    endtask

    task automatic feed(input bit gaps, input bit poke);
        int k = 0;
        int guard = 0;
        bit acc;
        while (k < bsum.size() && guard < 400) begin
            i_in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            i_in_sum   = IN_W'(bsum[k]);
            i_in_shift = SHIFT_W'(bsh[k]);
            i_start    = poke && (k == 1);
            if (poke && k == 1) i_cfg_len = 8'd1;
            acc = i_in_valid && o_in_ready;
            @(negedge clk);
            if (acc) k++;
            guard++;
        end
        i_in_valid = 1'b0;
        i_start = 1'b0;
        if (k < bsum.size()) chk("feed_timeout", k, bsum.size());
    endtask

    task automatic check_done(input string tag, input int stall);
        longint ed;
        bit eo;
        model(ACC_W, ed, eo);
        chk({tag, "_valid"}, o_out_valid, 1);
        chk({tag, "_data"}, longint'($signed(o_out_data)), ed);
        chk({tag, "_ovf"}, o_out_ovf, eo);
        chk({tag, "_in_ready"}, o_in_ready, 0);
        chk({tag, "_busy"}, o_busy, 1);
        repeat (stall) begin
            i_in_valid = 1'b1;
            i_in_sum   = IN_W'($urandom);
            @(negedge clk);
            chk({tag, "_hold_valid"}, o_out_valid, 1);
            chk({tag, "_hold_data"}, longint'($signed(o_out_data)), ed);
        end
        i_in_valid = 1'b0;
    endtask

    task automatic release_out(input string tag);
        i_out_ready = 1'b1;
        @(negedge clk);
        i_out_ready = 1'b0;
        chk({tag, "_idle_valid"}, o_out_valid, 0);
        chk({tag, "_idle_busy"}, o_busy, 0);
    endtask

    task automatic job20(input string tag);
        longint ed;
        bit eo;
        model(20, ed, eo);
        @(negedge clk);
        t_start = 1'b1;
        t_cfg_len = 8'd2;
        @(negedge clk);
        t_start = 1'b0;
        foreach (bsum[k]) begin
            t_in_valid = 1'b1;
            t_in_sum   = IN_W'(bsum[k]);
            t_in_shift = SHIFT_W'(bsh[k]);
            @(negedge clk);
        end
        t_in_valid = 1'b0;
        chk({tag, "_valid"}, t_out_valid, 1);
        chk({tag, "_data"}, longint'($signed(t_out_data)), ed);
        chk({tag, "_ovf"}, t_out_ovf, eo);
        t_out_ready = 1'b1;
        @(negedge clk);
        t_out_ready = 1'b0;
        chk({tag, "_idle"}, t_busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready", o_in_ready, 0);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_out_data", longint'(o_out_data), 0);
        chk("rst_out_ovf", o_out_ovf, 0);
        chk("rst_busy", o_busy, 0);
        rst_n = 1'b1;

        // Four-beat dot product, held output with in_sum churning.
        bsum = '{5, 3, -2, 1};
        bsh  = '{0, 2, 4, 6};
        start_job(4);
        feed(1'b0, 1'b0);
        chk("dp4_model", longint'($signed(o_out_data)), 49);
        check_done("dp4", 5);
        release_out("dp4");

        // Zero length behaves as one beat.
        bsum = '{-7};
        bsh  = '{3};
        start_job(0);
        feed(1'b0, 1'b0);
        check_done("len0", 0);
        chk("len0_raw", longint'(o_out_data), 64'hFFFF_FFC8);
        release_out("len0");

        // Narrow accumulator: wrap with overflow, then a clean run.
        bsum = '{511, 511};
        bsh  = '{10, 10};
        job20("w20_ovf");
        chk("w20_expect", longint'($signed(t_out_data)), -2048);
        bsum = '{100, -3};
        bsh  = '{0, 2};
        job20("w20_clean");

        // Mid-ACCUM start ignored; DONE handshake + start chains straight into ACCUM.
        bsum = '{7, -1, 4};
        bsh  = '{1, 3, 0};
        start_job(3);
        feed(1'b0, 1'b1);
        check_done("poke", 0);
        i_out_ready = 1'b1;
        i_start = 1'b1;
        i_cfg_len = 8'd1;
        @(negedge clk);
        i_out_ready = 1'b0;
        i_start = 1'b0;
        chk("chain_in_ready", o_in_ready, 1);
        chk("chain_busy", o_busy, 1);
        bsum = '{2};
        bsh  = '{0};
        feed(1'b0, 1'b0);
        check_done("chain", 1);
        release_out("chain");

        // Reset part-way through a run.
        bsum = '{100, 200};
        bsh  = '{5, 5};
        start_job(4);
        feed(1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", o_in_ready, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_data", longint'(o_out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bsum = '{1};
        bsh  = '{0};
        start_job(1);
        feed(1'b0, 1'b0);
        check_done("post_rst", 0);
        release_out("post_rst");

        // Random jobs with input gaps and output back-pressure.
        for (int j = 0; j < 12; j++) begin
            int len;
            len = $urandom_range(0, 6);
            bsum.delete();
            bsh.delete();
            for (int b = 0; b < ((len == 0) ? 1 : len); b++) begin
                bsum.push_back(int'($urandom_range(0, 1023)) - 512);
                bsh.push_back(int'($urandom_range(0, 15)));
            end
            start_job(len);
            feed(1'b1, 1'b0);
            check_done("rnd", $urandom_range(0, 3));
            release_out("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Consumes the 10-bit signed partial sums produced by a fusion-unit PE, one per cycle, each tagged with a left-shift amount for its bit-brick position.
- Shift-adds a programmed number of them into a wide accumulator and presents the finished dot-product result on a valid/ready output.
- Sits directly downstream of the PE, between the PE array and the output buffer/writeback.

Parameters:
- IN_W, 10, width of the incoming PE partial sum (two's complement).
- SHIFT_W, 4, width of the shift tag; shifts 0..2^SHIFT_W-1.
- ACC_W, 32, accumulator and result width (two's complement).
- CNT_W, 8, width of the beat-count configuration.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; reset==0 clears all state immediately.
- start  in  1  one-cycle pulse; begins a new accumulation. Honoured only in IDLE, or in DONE on the handshake cycle.
- cfg_len  in  CNT_W  number of partial sums per result; sampled with start; 0 treated as 1.
- in_valid  in  1  partial sum present.
- in_ready  out  1  block accepts a partial sum this cycle.
- in_sum  in  IN_W  signed partial sum from the PE.
- in_shift  in  SHIFT_W  left-shift applied to in_sum before adding.
- out_valid  out  1  result available.
- out_ready  in  1  downstream consumes the result.
- out_data  out  ACC_W  signed accumulated result.
- out_ovf  out  1  signed overflow occurred during this result; qualified by out_valid.
- busy  out  1  high in ACCUM or DONE.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, out_ovf=0, busy=0, state=IDLE, acc=0, cnt=0, len=0.
- States:
  - IDLE: in_ready=0, out_valid=0. On start: len<=max(cfg_len,1), acc<=0, cnt<=0, ovf<=0, go ACCUM.
  - ACCUM: in_ready=1. A beat is accepted when in_valid && in_ready. On accept: operand = sign-extend(in_sum) to ACC_W, then shift left by in_shift, truncated to ACC_W. Then acc<=acc+operand, cnt<=cnt+1. If cnt==len-1 on accept: out_data<=acc+operand, out_ovf<=ovf|ovf_this_beat, go DONE.
  - DONE: out_valid=1, in_ready=0; out_data/out_ovf held stable. On out_valid&&out_ready: if start is also high, reload exactly as from IDLE and go ACCUM; otherwise go IDLE.
- Latency: out_valid rises the cycle after the last beat is accepted. No combinational path from in_* or out_ready to out_*; in_ready and out_valid are decoded from registered state only.
- Overflow: the beat flag is set when the two addend signs are equal and differ from the sum sign. It is sticky per result. The result wraps modulo 2^ACC_W (no saturation). Bits shifted out above ACC_W are silently dropped.
- start while in ACCUM, or in DONE without a handshake: ignored; no state change.
- in_valid while IDLE/DONE: not accepted, no effect.
- cnt is CNT_W bits; len up to 2^CNT_W-1. cnt never wraps because termination occurs at len-1.
- reset asserted mid-operation: partial accumulation discarded, outputs return to reset values asynchronously.

Decomposition:
- Package psum_pkg:
  - state encoding (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2);
  - default widths IN_W/SHIFT_W/ACC_W/CNT_W;
  - a function for the signed-overflow check.
- Sub-module psum_shift_ext: combinational sign-extend-and-shift (in_sum, in_shift -> ACC_W operand).
- FSM, counter and accumulator registers stay in psum_accumulator.

Test Plan:
- start, cfg_len=4; beats (5,sh0),(3,sh2),(-2,sh4),(1,sh6), in_valid held high -> out_valid one cycle after 4th accept, out_data=49, out_ovf=0, in_ready low while out_valid.
- Same run with out_ready held 0 for 5 cycles -> out_data stays 49 and out_valid stays 1 throughout; in_sum toggling has no effect; out_ready=1 -> IDLE next cycle.
- cfg_len=0, one beat (-7,sh3) -> treated as length 1; out_data=-56 (0xFFFFFFC8).
- ACC_W=20 override, cfg_len=2, beats (511,sh10),(511,sh10) -> out_data=-2048 (wrapped), out_ovf=1; next run with no overflow -> out_ovf=0.
- In DONE, assert out_ready and start (cfg_len=1) in the same cycle -> goes straight to ACCUM; beat (2,sh0) -> out_data=2. start pulsed in mid-ACCUM -> ignored; count and result unchanged.
- Drive reset=0 after 2 of 4 beats -> outputs cleared immediately. Release reset; new start with cfg_len=1, beat (1,sh0) -> out_data=1, no residue from the aborted run.
